// File: rtl/cute_lock_pkg.sv
// Shared types and helpers for the Cute-Lock key sequencer.
//   seq_state_t : sequencer FSM states
//   cnt_width() : counter width for a given number of values, never below 1
//   KEY_ZERO    : idle key bit, replicated to the key bus width by users
package cute_lock_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } seq_state_t;

  localparam logic KEY_ZERO = 1'b0;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cute_key_table.sv
// Key schedule storage: NUM_STATES entries of KEY_BITS each.
// Serial bits enter at the top of a flat shift register, so after
// NUM_STATES*KEY_BITS shifts bit i of the stream sits at flat position i,
// which is entry i / KEY_BITS, bit i % KEY_BITS.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clr          : synchronous clear of the whole table
//   shift_en     : shift shift_in into the table this cycle
//   shift_in     : serial key bit
//   rd_idx       : entry index for the read port
//   rd_data      : entry contents (combinational)
module cute_key_table #(
  parameter int KEY_BITS   = 1,
  parameter int NUM_STATES = 2,
  parameter int CNT_W      = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clr,
  input  logic                shift_en,
  input  logic                shift_in,
  input  logic [CNT_W-1:0]    rd_idx,
  output logic [KEY_BITS-1:0] rd_data
);

  localparam int TOTAL = NUM_STATES * KEY_BITS;

  logic [TOTAL-1:0] tbl_q, tbl_d;

  always_comb begin
    tbl_d = tbl_q;
    if (clr) begin
      tbl_d = '0;
    end else if (shift_en) begin
      tbl_d            = tbl_q >> 1;
      tbl_d[TOTAL-1]   = shift_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) tbl_q <= '0;
    else       tbl_q <= tbl_d;
  end

  always_comb begin
    rd_data = '0;
    for (int e = 0; e < NUM_STATES; e++) begin
      if (rd_idx == CNT_W'(e)) rd_data = tbl_q[e*KEY_BITS +: KEY_BITS];
    end
  end

endmodule

// File: rtl/cute_key_sequencer.sv
// Replays a serially loaded key schedule onto a Cute-Lock core's key bus,
// one entry per cycle, in lock-step with the core's state counter.
//
//   state | meaning
//   LOAD  | accepting serial key bits, load_ready high
//   ARMED | schedule complete, key bus held at zero, waiting for start
//   RUN   | key_out = table[count_state], count wraps at NUM_STATES-1
//
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   load_valid/data/ready : serial key provisioning handshake
//   start, stop, clear    : replay control (priority clear > stop > start)
//   key_out               : key applied to the locked core (registered)
//   count_state           : current schedule index (registered)
//   running, armed        : status flags (registered)
module cute_key_sequencer
  import cute_lock_pkg::*;
#(
  parameter int KEY_BITS   = 1,
  parameter int NUM_STATES = 2,
  parameter int CNT_W      = cnt_width(NUM_STATES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_valid,
  input  logic                load_data,
  output logic                load_ready,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  output logic [KEY_BITS-1:0] key_out,
  output logic [CNT_W-1:0]    count_state,
  output logic                running,
  output logic                armed
);

  localparam int TOTAL = NUM_STATES * KEY_BITS;
  localparam int BIT_W = cnt_width(TOTAL);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_ENTRY = CNT_W'(NUM_STATES - 1);

  seq_state_t          state_q, state_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic                running_q, running_d;
  logic                armed_q, armed_d;
  logic                shift_en, tbl_clr;
  logic [KEY_BITS-1:0] rd_data;

  assign load_ready = (state_q == LOAD);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = '0;
    shift_en  = 1'b0;
    tbl_clr   = 1'b0;

    case (state_q)
      LOAD: begin
        if (load_valid) begin
          shift_en = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ARMED;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ARMED: begin
        if (!stop && start) state_d = RUN;
      end
      RUN: begin
        if (stop) state_d = ARMED;
        else      cnt_d   = (cnt_q == LAST_ENTRY) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = LOAD;
    endcase

    if (clear) begin
      state_d   = LOAD;
      bit_cnt_d = '0;
      cnt_d     = '0;
      shift_en  = 1'b0;
      tbl_clr   = 1'b1;
    end

    // Key is looked up with the next index so it lands together with count_state.
    key_d     = (state_d == RUN) ? rd_data : {KEY_BITS{KEY_ZERO}};
    running_d = (state_d == RUN);
    armed_d   = (state_d == ARMED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= LOAD;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      running_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      running_q <= running_d;
      armed_q   <= armed_d;
    end
  end

  cute_key_table #(
    .KEY_BITS  (KEY_BITS),
    .NUM_STATES(NUM_STATES),
    .CNT_W     (CNT_W)
  ) u_table (
    .clock   (clock),
    .reset   (reset),
    .clr     (tbl_clr),
    .shift_en(shift_en),
    .shift_in(load_data),
    .rd_idx  (cnt_d),
    .rd_data (rd_data)
  );

  assign key_out     = key_q;
  assign count_state = cnt_q;
  assign running     = running_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_cute_key_sequencer.sv
module tb_cute_key_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Instance A: KEY_BITS=1, NUM_STATES=2
  logic       a_reset = 1'b0, a_load_valid = 1'b0, a_load_data = 1'b0;
  logic       a_start = 1'b0, a_stop = 1'b0, a_clear = 1'b0;
  logic       a_load_ready, a_running, a_armed;
  logic [0:0] a_key;
  logic [0:0] a_cnt;

  // Instance B: KEY_BITS=2, NUM_STATES=3
  logic       b_reset = 1'b0, b_load_valid = 1'b0, b_load_data = 1'b0;
  logic       b_start = 1'b0, b_stop = 1'b0, b_clear = 1'b0;
  logic       b_load_ready, b_running, b_armed;
  logic [1:0] b_key;
  logic [1:0] b_cnt;

  cute_key_sequencer #(.KEY_BITS(1), .NUM_STATES(2)) dut_a (
    .clock(clock), .reset(a_reset),
    .load_valid(a_load_valid), .load_data(a_load_data), .load_ready(a_load_ready),
    .start(a_start), .stop(a_stop), .clear(a_clear),
    .key_out(a_key), .count_state(a_cnt), .running(a_running), .armed(a_armed)
  );

  cute_key_sequencer #(.KEY_BITS(2), .NUM_STATES(3)) dut_b (
    .clock(clock), .reset(b_reset),
    .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
    .start(b_start), .stop(b_stop), .clear(b_clear),
    .key_out(b_key), .count_state(b_cnt), .running(b_running), .armed(b_armed)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compact status vector for A: {load_ready, running, armed, key, cnt}
  function automatic logic [4:0] a_stat();
    return {a_load_ready, a_running, a_armed, a_key, a_cnt};
  endfunction

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0;
    checks++;
    if (a_stat() !== 5'b1_0_0_0_0) begin
      failures++;
      $display("FAIL reset_a status got=%b exp=%b", a_stat(), 5'b10000);
    end
    checks++;
    if ({b_load_ready, b_running, b_armed, b_key, b_cnt} !== 7'b1_0_0_00_00) begin
      failures++;
      $display("FAIL reset_b status got=%b exp=%b",
               {b_load_ready, b_running, b_armed, b_key, b_cnt}, 7'b1000000);
    end
  endtask

  task automatic test_load_run();
    logic [0:0] exp_k [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [0:0] exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    a_load_valid = 1'b1; a_load_data = 1'b1;
    tick();
    checks++;
    if (a_stat() !== 5'b1_0_0_0_0) begin
      failures++;
      $display("FAIL load_bit0 status got=%b exp=%b", a_stat(), 5'b10000);
    end
    a_load_data = 1'b0;
    tick();
    a_load_valid = 1'b0;
    checks++;
    if (a_stat() !== 5'b0_0_1_0_0) begin
      failures++;
      $display("FAIL load_armed status got=%b exp=%b", a_stat(), 5'b00100);
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_stat() !== {3'b010, exp_k[i], exp_c[i]}) begin
        failures++;
        $display("FAIL run_seq[%0d] status got=%b exp=%b", i, a_stat(),
                 {3'b010, exp_k[i], exp_c[i]});
      end
      tick();
    end
  endtask

  task automatic test_stop();
    // Running at index 0 here.
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    checks++;
    if (a_stat() !== 5'b0_0_1_0_0) begin
      failures++;
      $display("FAIL stop_armed status got=%b exp=%b", a_stat(), 5'b00100);
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick(); tick();
    checks++;
    if (a_stat() !== 5'b0_1_0_1_0) begin
      failures++;
      $display("FAIL run_cycle3 status got=%b exp=%b", a_stat(), 5'b01010);
    end
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
    checks++;
    if (a_stat() !== 5'b0_0_1_0_0) begin
      failures++;
      $display("FAIL stop_cycle3 status got=%b exp=%b", a_stat(), 5'b00100);
    end
    a_start = 1'b1;
    tick();
    checks++;
    if (a_stat() !== 5'b0_1_0_1_0) begin
      failures++;
      $display("FAIL replay_first status got=%b exp=%b", a_stat(), 5'b01010);
    end
    tick();
    a_start = 1'b0;
    checks++;
    if (a_stat() !== 5'b0_1_0_0_1) begin
      failures++;
      $display("FAIL start_no_restart status got=%b exp=%b", a_stat(), 5'b01001);
    end
  endtask

  task automatic test_clear_stop();
    a_clear = 1'b1; a_stop = 1'b1;
    tick();
    a_clear = 1'b0; a_stop = 1'b0;
    checks++;
    if (a_stat() !== 5'b1_0_0_0_0) begin
      failures++;
      $display("FAIL clear_stop status got=%b exp=%b", a_stat(), 5'b10000);
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if (a_stat() !== 5'b1_0_0_0_0) begin
      failures++;
      $display("FAIL start_after_clear status got=%b exp=%b", a_stat(), 5'b10000);
    end
  endtask

  task automatic test_reset_mid_load();
    a_load_valid = 1'b1; a_load_data = 1'b1;
    tick();
    a_load_valid = 1'b0;
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    a_load_valid = 1'b1; a_load_data = 1'b0;
    tick();
    checks++;
    if (a_stat() !== 5'b1_0_0_0_0) begin
      failures++;
      $display("FAIL reload_bit0 status got=%b exp=%b", a_stat(), 5'b10000);
    end
    a_load_data = 1'b1;
    tick();
    a_load_valid = 1'b0;
    checks++;
    if (a_stat() !== 5'b0_0_1_0_0) begin
      failures++;
      $display("FAIL reload_armed status got=%b exp=%b", a_stat(), 5'b00100);
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if (a_stat() !== 5'b0_1_0_0_0) begin
      failures++;
      $display("FAIL reload_key0 status got=%b exp=%b", a_stat(), 5'b01000);
    end
    tick();
    checks++;
    if (a_stat() !== 5'b0_1_0_1_1) begin
      failures++;
      $display("FAIL reload_key1 status got=%b exp=%b", a_stat(), 5'b01011);
    end
  endtask

  task automatic test_reset_mid_run();
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    checks++;
    if (a_stat() !== 5'b1_0_0_0_0) begin
      failures++;
      $display("FAIL reset_mid_run status got=%b exp=%b", a_stat(), 5'b10000);
    end
  endtask

  task automatic test_gap_wrap();
    logic       bits  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] exp_k [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [1:0] exp_c [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        b_load_valid = 1'b0;
        b_load_data  = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({b_load_ready, b_armed} !== 2'b10) begin
          failures++;
          $display("FAIL gap_hold ready_armed got=%b exp=%b", {b_load_ready, b_armed}, 2'b10);
        end
      end
      b_load_valid = 1'b1;
      b_load_data  = bits[i];
      tick();
    end
    b_load_valid = 1'b0;
    checks++;
    if ({b_load_ready, b_armed, b_running} !== 3'b010) begin
      failures++;
      $display("FAIL b_armed ready_armed_running got=%b exp=%b",
               {b_load_ready, b_armed, b_running}, 3'b010);
    end
    // load_valid while ARMED must not disturb the stored schedule.
    b_load_valid = 1'b1; b_load_data = 1'b0;
    tick();
    b_load_valid = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({b_running, b_key, b_cnt} !== {1'b1, exp_k[i], exp_c[i]}) begin
        failures++;
        $display("FAIL b_run_seq[%0d] running_key_cnt got=%b exp=%b", i,
                 {b_running, b_key, b_cnt}, {1'b1, exp_k[i], exp_c[i]});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_stop();
    test_clear_stop();
    test_reset_mid_load();
    test_reset_mid_run();
    test_gap_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cute_key_sequencer.md
Name: cute_key_sequencer

Overview:
- Drives the time-varying key bus of a Cute-Lock-encrypted sequential benchmark.
- Each cycle, a locked design's key-controlled next-state mux needs a key value chosen by an internal state counter.
- This block holds the secret key schedule, loaded serially, and replays it entry by entry in lock-step with that counter.
- It sits between the key-provisioning interface and the locked core's keyinput pins.

Parameters:
- KEY_BITS, 1, width of the key bus applied to the locked core per cycle.
- NUM_STATES, 2, number of schedule entries; this is the counter period (2 matches a single toggling counter bit).
- CNT_W, max(1, clog2(NUM_STATES)), width of the schedule counter (derived).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  serial key bit present.
- load_data  in  1  serial key bit.
- load_ready  out  1  block accepts a key bit this cycle.
- start  in  1  begin replay (one-cycle pulse or level).
- stop  in  1  halt replay.
- clear  in  1  discard loaded schedule.
- key_out  out  KEY_BITS  key applied to locked core.
- count_state  out  CNT_W  current schedule index, mirrors core counter.
- running  out  1  replay active.
- armed  out  1  schedule fully loaded, not running.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: state=LOAD, bit counter=0, table=0, key_out=0, count_state=0, running=0, armed=0. load_ready=1 in the first cycle after reset.
- FSM states: LOAD, ARMED, RUN. All outputs are registered except load_ready, which is (state==LOAD).
- LOAD:
  - A bit is accepted on load_valid & load_ready and shifted in.
  - Bit i goes to table[i / KEY_BITS][i % KEY_BITS]: entry 0 first, LSB first within an entry.
  - The bit counter runs 0..NUM_STATES*KEY_BITS-1.
  - On acceptance of the last bit, next state is ARMED and armed=1 from the next cycle.
  - start and stop are ignored in LOAD.
- ARMED:
  - key_out=0, count_state=0.
  - start=1 leads to RUN next cycle.
  - load_valid is ignored.
- RUN:
  - In the first RUN cycle, count_state=0 and key_out=table[0]. Latency from start edge to the first key is 1 cycle.
  - Each later cycle: count_state increments and wraps NUM_STATES-1 to 0; key_out=table[count_state] in the same cycle.
  - running=1, armed=0.
  - start while in RUN has no effect (it does not restart the count).
  - stop=1 leads to ARMED next cycle with key_out=0 and count_state=0. The table is retained.
- clear=1 in any state: next state LOAD, table=0, bit counter=0, key_out=0, running=0, armed=0.
- Priority when inputs coincide: reset > clear > stop > start.
- Reset mid-load: the partially loaded table is zeroed and loading restarts at bit 0.
- Reset mid-run: key_out=0 in the next cycle.
- The table is never visible on key_out outside RUN. It has no read-back port.

Decomposition:
- Shared package cute_lock_pkg holds:
  - the seq_state_t enum {LOAD, ARMED, RUN};
  - a clog2-based width function for CNT_W;
  - the constant KEY_ZERO.
- One sub-module, cute_key_table: a NUM_STATES x KEY_BITS shift-load register file with shift-enable, synchronous clear, and an indexed read port. The FSM, bit counter and schedule counter stay in the top module.

Test Plan:
- KEY_BITS=1, NUM_STATES=2; load bits 1,0; start pulse -> armed=1 after the 2nd bit; key_out sequence 1,0,1,0 with count_state 0,1,0,1 starting the cycle after start.
- KEY_BITS=2, NUM_STATES=3; load 6 bits 1,0,0,1,1,1 (entries 2'b01, 2'b10, 2'b11); start -> key_out 01,10,11,01 (wrap at index 2 to 0).
- load_valid held low for 3 cycles mid-load, then resumed -> no bit lost; the final table equals the serialized values.
- stop asserted in the 3rd RUN cycle -> next cycle running=0, armed=1, key_out=0; a later start replays from table[0].
- clear and stop asserted together in RUN -> state LOAD, load_ready=1, table=0; a following start without loading has no effect.
- reset asserted after 1 of 2 bits loaded -> bit counter 0; reloading 0,1 gives key_out 0,1 on start.
